// File: rtl/gat_pkg.sv
// Shared GAT parameters, the aggregator FSM encoding and the BRAM base-address helper.
package gat_pkg;

  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NEW_FEATURE_WIDTH  = 16;
  localparam int NEW_FEATURE_ADDR_W = 12;

  localparam int COEF_WIDTH  = 16;
  localparam int COEF_FRAC_W = 8;
  localparam int AGGR_WIDTH  = 32;
  localparam int NODE_ID_W   = 10;
  localparam int BRAM_RD_LAT = 2;

  // Width of a word index inside one feature vector.
  localparam int FEAT_IDX_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } aggr_state_e;

  // Node n starts at n*NUM_FEATURE_OUT. Out-of-range bases wrap silently.
  function automatic logic [NEW_FEATURE_ADDR_W-1:0] feat_base_addr(
    input logic [NODE_ID_W-1:0] node
  );
    logic [NEW_FEATURE_ADDR_W+NODE_ID_W-1:0] wide;
    wide = (NEW_FEATURE_ADDR_W+NODE_ID_W)'(node) *
           (NEW_FEATURE_ADDR_W+NODE_ID_W)'(NUM_FEATURE_OUT);
    return wide[NEW_FEATURE_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/aggr_mac.sv
// One-word multiply / floor-shift / accumulate for the feature aggregator.
// FEATURE_AGGR_SAT_EN: when defined the shifted product and the sum saturate
// to the signed AGGR_WIDTH range; otherwise everything wraps.
module aggr_mac
  import gat_pkg::*;
(
  input  logic signed [NEW_FEATURE_WIDTH-1:0] feat_i,
  input  logic signed [COEF_WIDTH-1:0]        coef_i,
  input  logic signed [AGGR_WIDTH-1:0]        acc_i,
  output logic signed [AGGR_WIDTH-1:0]        acc_o
);

  localparam int PW = NEW_FEATURE_WIDTH + COEF_WIDTH;

  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         shifted;
  logic signed [AGGR_WIDTH-1:0] term;

  // Full-width signed product, then arithmetic shift (floor toward -inf).
  assign prod    = feat_i * coef_i;
  assign shifted = prod >>> COEF_FRAC_W;

`ifdef FEATURE_AGGR_SAT_EN
  localparam logic [AGGR_WIDTH-1:0] SAT_MAX = {1'b0, {(AGGR_WIDTH-1){1'b1}}};
  localparam logic [AGGR_WIDTH-1:0] SAT_MIN = {1'b1, {(AGGR_WIDTH-1){1'b0}}};
`endif

  // Bring the shifted product to accumulator width.
  if (AGGR_WIDTH >= PW) begin : g_ext
    assign term = AGGR_WIDTH'(shifted);
  end else begin : g_narrow
`ifdef FEATURE_AGGR_SAT_EN
    assign term = ((&shifted[PW-1:AGGR_WIDTH-1]) || !(|shifted[PW-1:AGGR_WIDTH-1]))
                  ? shifted[AGGR_WIDTH-1:0]
                  : (shifted[PW-1] ? SAT_MIN : SAT_MAX);
`else
    assign term = shifted[AGGR_WIDTH-1:0];
`endif
  end

`ifdef FEATURE_AGGR_SAT_EN
  logic signed [AGGR_WIDTH:0] sum_ext;

  // Add with one guard bit and clamp on signed overflow.
  always_comb begin
    sum_ext = {acc_i[AGGR_WIDTH-1], acc_i} + {term[AGGR_WIDTH-1], term};
    if (sum_ext[AGGR_WIDTH] != sum_ext[AGGR_WIDTH-1]) begin
      acc_o = sum_ext[AGGR_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_o = sum_ext[AGGR_WIDTH-1:0];
    end
  end
`else
  // Two's-complement wrap.
  always_comb begin
    acc_o = acc_i + term;
  end
`endif

endmodule

// File: rtl/feature_aggregator.sv
// Weighted neighbour-feature aggregation for one destination node at a time.
// For every accepted (node, coef) pair it streams the node's feature vector
// out of BRAM port B and accumulates (word*coef)>>>COEF_FRAC_W per element;
// the pair flagged last releases the vector on aggr_feat_vld/aggr_feat_rdy.
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high; the aggregated vector and its valid are held until then.
// Optional macro FEATURE_AGGR_SAT_EN selects saturating accumulation.
module feature_aggregator
  import gat_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [COEF_WIDTH-1:0]                     coef,
  input  logic [NODE_ID_W-1:0]                      coef_node,
  input  logic                                      coef_last,
  input  logic                                      coef_vld,
  output logic                                      coef_rdy,
  output logic [NEW_FEATURE_ADDR_W-1:0]             feat_bram_addrb,
  output logic                                      feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0]              feat_bram_doutb,
  output logic [NUM_FEATURE_OUT*AGGR_WIDTH-1:0]     aggr_feat,
  output logic                                      aggr_feat_vld,
  input  logic                                      aggr_feat_rdy,
  output aggr_state_e                               dbg_state_o
);

  localparam int DR_W = $clog2(BRAM_RD_LAT + 1);

  aggr_state_e                   state_q, state_d;
  logic [FEAT_IDX_W-1:0]         k_q, k_d;
  logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
  logic                          enb_q, enb_d;
  logic                          rdy_q, rdy_d;
  logic                          vld_q, vld_d;
  logic [COEF_WIDTH-1:0]         coef_q, coef_d;
  logic                          last_q, last_d;
  logic [DR_W-1:0]               drain_q, drain_d;
  logic                          acc_clr;

  logic                          pipe_v_q [BRAM_RD_LAT];
  logic [FEAT_IDX_W-1:0]         pipe_k_q [BRAM_RD_LAT];
  logic signed [AGGR_WIDTH-1:0]  acc_q    [NUM_FEATURE_OUT];

  logic                          ret_v;
  logic [FEAT_IDX_W-1:0]         ret_idx;
  logic signed [AGGR_WIDTH-1:0]  mac_out;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    enb_d   = 1'b0;
    vld_d   = vld_q;
    coef_d  = coef_q;
    last_d  = last_q;
    drain_d = drain_q;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (coef_vld && rdy_q) begin
          coef_d  = coef;
          last_d  = coef_last;
          addr_d  = feat_base_addr(coef_node);
          k_d     = '0;
          enb_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        addr_d = addr_q + 1'b1;
        k_d    = k_q + 1'b1;
        enb_d  = 1'b1;
        if (k_q == FEAT_IDX_W'(NUM_FEATURE_OUT - 1)) begin
          enb_d   = 1'b0;
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DR_W'(BRAM_RD_LAT - 1)) begin
          state_d = last_q ? OUT : IDLE;
          vld_d   = last_q;
        end
      end
      OUT: begin
        if (aggr_feat_rdy) begin
          vld_d   = 1'b0;
          acc_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  // FSM and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      enb_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      coef_q  <= '0;
      last_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      enb_q   <= enb_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      coef_q  <= coef_d;
      last_q  <= last_d;
      drain_q <= drain_d;
    end
  end

  // Read-return tracker: carries (valid, offset) alongside each BRAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BRAM_RD_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_k_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0] <= enb_q;
      pipe_k_q[0] <= k_q;
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_k_q[i] <= pipe_k_q[i-1];
      end
    end
  end

  // Offset k holds element N-1-k, so the returning offset is mirrored.
  assign ret_v   = pipe_v_q[BRAM_RD_LAT-1];
  assign ret_idx = FEAT_IDX_W'(NUM_FEATURE_OUT - 1) - pipe_k_q[BRAM_RD_LAT-1];

  aggr_mac u_mac (
    .feat_i (feat_bram_doutb),
    .coef_i (coef_q),
    .acc_i  (acc_q[ret_idx]),
    .acc_o  (mac_out)
  );

  // Accumulator bank: one addressed word per return, cleared on output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_FEATURE_OUT; j++) acc_q[j] <= '0;
    end else if (acc_clr) begin
      for (int j = 0; j < NUM_FEATURE_OUT; j++) acc_q[j] <= '0;
    end else if (ret_v) begin
      acc_q[ret_idx] <= mac_out;
    end
  end

  // Pack accumulators onto the output bus, element 0 in the low word.
  always_comb begin
    aggr_feat = '0;
    for (int j = 0; j < NUM_FEATURE_OUT; j++) begin
      aggr_feat[j*AGGR_WIDTH +: AGGR_WIDTH] = acc_q[j];
    end
  end

  assign coef_rdy        = rdy_q;
  assign feat_bram_enb   = enb_q;
  assign feat_bram_addrb = addr_q;
  assign aggr_feat_vld   = vld_q;
  assign dbg_state_o     = state_q;

endmodule
